// File: rtl/rt_out_arbiter.sv
// rtl/rt_out_arbiter.sv - round-robin output-port arbiter with frame-based ownership
// Optional ownership timeout enabled by defining RT_ARB_TIMEOUT_EN.
module rt_out_arbiter #(
  parameter int NPORT     = 16,
  parameter int TO_CYCLES = 1024,
  localparam int IW       = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] frame_done,
  output logic [NPORT-1:0] grant,
  output logic [IW-1:0]    grant_id,
  output logic             grant_vld,
  output logic             busy_n,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, win_id, grant_id_nxt;
  logic [NPORT-1:0] grant_nxt;
  logic             win_found, owner_done, to_hit;

  assign owner_done = (state == OWN) && frame_done[grant_id];

`ifdef RT_ARB_TIMEOUT_EN
  localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [CW-1:0] cnt;

  // Held at zero outside OWN, so it is already clear on entry.
  always_ff @(posedge clock) begin
    if (reset || state != OWN) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign to_hit = (state == OWN) && (cnt == CW'(TO_CYCLES - 1)) && !owner_done;
`else
  assign to_hit = 1'b0;
`endif

  // Rotating search: first requester at or above ptr, wrapping at NPORT.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NPORT; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NPORT) j = j - NPORT;
      if (!win_found && req[j[IW-1:0]]) begin
        win_found = 1'b1;
        win_id    = j[IW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt         = OWN;
          grant_nxt         = '0;
          grant_nxt[win_id] = 1'b1;
          grant_id_nxt      = win_id;
        end
      end
      OWN: begin
        if (owner_done || to_hit) begin
          state_nxt    = RELEASE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
          ptr_nxt      = (grant_id == IW'(NPORT - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_vld = (state == OWN);
    busy_n    = (state != OWN);
    timeout   = to_hit;
  end

endmodule
